shift_add_multiplier: RTL and testbench

- Sequential unsigned shift-and-add multiplier; the arithmetic inverse of the team's combinational restoring divider.
- Takes WIDTH-bit operands A and B under a start/busy/done handshake.
- Computes one partial-product bit per clock and presents a registered 2*WIDTH-bit product.
- Used wherever the datapath must rebuild a dividend from quotient and divisor, e.g. divider self-check.

---
 rtl/shift_add_multiplier.sv | 102 ++++++++++
 tb/tb_shift_add_multiplier.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial-product bit per clock,
// registered 2*WIDTH-bit product, start/busy/done handshake.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start; operands not held
    // RUN   | WIDTH add/shift steps, one per clock
    // DONE  | one-cycle done pulse; product freshly updated
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        product_d = product_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // Carry out of the upper half is kept as bit WIDTH of the sum.
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            // The DONE exit edge also samples start, so a held start yields a
            // result every WIDTH+1 cycles.
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    mcand_d = A;
                    acc_d   = {{WIDTH{1'b0}}, B};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    product_d = {sum, acc_q[WIDTH-1:1]};
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: timer-based reference model checked every cycle,
// plus directed, random back-to-back and exhaustive operand tests.
module tb_shift_add_multiplier;

    localparam int W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (A),
        .B       (B),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted operation keeps busy for W+1 cycles, the
    // product A*B appears with done in the last of them.
    int             t_left;
    logic [2*W-1:0] pend;
    logic [2*W-1:0] prod_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_left = 0;
            prod_m = '0;
            pend   = '0;
        end else if (t_left <= 1 && start) begin
            pend   = (2*W)'(A) * (2*W)'(B);
            t_left = W + 1;
        end else if (t_left > 0) begin
            t_left = t_left - 1;
            if (t_left == 1) prod_m = pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("product", product, prod_m);
            chk("busy", busy, (t_left > 0));
            chk("done", done, (t_left == 1));
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] p);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        wait_done();
        p = product;
    endtask

    logic [2*W-1:0] p;
    int busy_cnt;
    int done_at;
    int done_cnt;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk("reset_product", product, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        chk_en = 1;

        // 6*1: busy for 5 cycles, done in cycle 4 after the start edge
        @(negedge clk);
        A = 4'd6;
        B = 4'd1;
        start = 1'b1;
        busy_cnt = 0;
        done_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) done_at = k - 1;
        end
        chk("six_busy_cycles", busy_cnt, 5);
        chk("six_done_cycle", done_at, 4);
        chk("six_product", product, 6);
        repeat (10) @(negedge clk);
        chk("six_hold", product, 6);

        do_op(4'd15, 4'd15, p);
        chk("p15x15", p, 225);
        chk("model15x15", prod_m, 225);
        do_op(4'd8, 4'd15, p);
        chk("p8x15", p, 120);
        do_op(4'd0, 4'd9, p);
        chk("p0x9", p, 0);
        do_op(4'd9, 4'd0, p);
        chk("p9x0", p, 0);

        // abort mid-run with reset
        @(negedge clk);
        A = 4'd13;
        B = 4'd11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        done_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        do_op(4'd3, 4'd5, p);
        chk("p3x5", p, 15);
        chk("model3x5", prod_m, 15);

        // start held high with operands changing every cycle
        @(negedge clk);
        A = W'($urandom);
        B = W'($urandom);
        start = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            A = W'($urandom);
            B = W'($urandom);
        end
        start = 1'b0;
        chk("b2b_results", done_cnt, 12);
        repeat (8) @(negedge clk);

        // exhaustive sweep, with division back to the multiplicand
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(W'(a), W'(b), p);
                chk("sweep", p, a * b);
                if (p <= 15 && b != 0) begin
                    chk("div_quotient", int'(p) / b, a);
                    chk("div_remainder", int'(p) % b, 0);
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
